gray_wptr_full: RTL and testbench
=================================

// Module: gray_wptr_full
// PURPOSE
//  Write-side pointer/flag generator for the async FIFO. Counts accepted writes in binary,
//  encodes the pointer binary->Gray for crossing into the read domain, and compares against
//  the read pointer (Gray, already 2-FF synchronised into wclk) to produce full/almost-full/level.
//  Sits between the write port and the dual-port RAM / pointer synchroniser.
// PARAMETERS
//  ADDRSIZE  8   RAM address width; FIFO depth = 2**ADDRSIZE; pointers are ADDRSIZE+1 bits
//  AFULL_TH  2**ADDRSIZE-2  occupancy at/above which wafull asserts (1..2**ADDRSIZE)
// PORTS
//  wclk       in   1           write-domain clock
//  wrst       in   1           synchronous reset, active-high
//  winc       in   1           write request (push this cycle)
//  wq2_rptr   in   ADDRSIZE+1  read pointer, Gray, synchronised into wclk
//  waddr      out  ADDRSIZE    RAM write address (binary)
//  wptr       out  ADDRSIZE+1  write pointer, Gray, registered, to read-domain synchroniser
//  wfull      out  1           FIFO full, registered
//  wafull     out  1           occupancy >= AFULL_TH, registered
//  wlevel     out  ADDRSIZE+1  occupancy 0..2**ADDRSIZE as seen from write side, registered
// BEHAVIOUR
//  - One clock (wclk); reset is synchronous and active-high (wrst). All state in wclk.
//  - Reset (wrst=1 at posedge): wbin=0, wptr=0, waddr=0, wfull=0, wafull=0, wlevel=0.
//    Reset mid-operation discards all pointer state; winc during reset cycle is ignored.
//  - Accept: push = winc & ~wfull. winc while wfull=1 is dropped (no pointer change, no error).
//  - wbin_next = wbin + push, modulo 2**(ADDRSIZE+1) (natural wrap, MSB is lap bit).
//  - wgray_next = (wbin_next >> 1) ^ wbin_next; wptr <= wgray_next every cycle.
//  - waddr = wbin[ADDRSIZE-1:0] (combinational from register); RAM write uses current waddr with push.
//  - Latency: accepted push at edge N -> waddr/wptr/wfull/wlevel updated after edge N (1 cycle).
//    Exactly one wptr bit toggles per accepted push; wptr never glitches (registered).
//  - Full: wfull <= (wgray_next == {~wq2_rptr[ADDRSIZE:ADDRSIZE-1], wq2_rptr[ADDRSIZE-2:0]}).
//    Requires ADDRSIZE >= 2. Full asserts the cycle after the push filling the last slot.
//  - Level: rbin = Gray->binary of wq2_rptr (MSB copy, then XOR-prefix downward);
//    wlevel <= (wbin_next - rbin) mod 2**(ADDRSIZE+1). wafull <= (that value >= AFULL_TH).
//  - Flags pessimistic: read progress seen only after sync delay; wfull/wafull deassert
//    late, never early. Simultaneous push and rptr advance: both folded into same next-state.
//  - wq2_rptr assumed single-bit-change per cycle; no checking of illegal Gray input.
// STRUCTURE
//  - Shared package (fifo_pkg): pointer-width function PTRW(ADDRSIZE)=ADDRSIZE+1,
//    functions bin2gray()/gray2bin_f() for reuse by read-side block and bench models.
//  - One natural sub-module: bin2gray (parameterised width, pure combinational XOR of
//    adjacent bits, MSB passthrough); counter, compare and level registers stay in top.
// TESTING  (ADDRSIZE=4, depth 16, AFULL_TH=14)
//  1 wrst=1 with winc=1 -> all outputs 0; release, 1 push -> waddr=1, wptr=5'b00001, wlevel=1.
//  2 16 pushes, wq2_rptr=0 -> wfull=1 after 16th, wptr=5'b11000, waddr=0; 17th winc -> no change.
//  3 14th push -> wafull=1, wlevel=14; 13 pushes -> wafull=0.
//  4 full, then wq2_rptr=5'b00001 -> next edge wfull=0, wlevel=15; push accepted -> wfull=1.
//  5 wrap: 40 pushes with rptr tracking (rptr=wptr two cycles late) -> wptr cycles 32-state
//    Gray sequence, one bit change per push, wfull never set, wlevel<=2.
//  6 wrst asserted while full -> next edge wptr=0, wfull=0, wlevel=0, wafull=0.

Source files
------------

// File: rtl/gray_wptr_full_pkg.sv
// Shared helpers for the async FIFO pointer logic: pointer width and Gray conversions.
// Conversions work on a 32-bit container; callers truncate to their own pointer width.
package gray_wptr_full_pkg;

    function automatic int unsigned ptrw(int unsigned addrsize);
        return addrsize + 1;
    endfunction

    function automatic logic [31:0] bin2gray(logic [31:0] b);
        return b ^ (b >> 1);
    endfunction

    // Gray to binary is a running XOR from the MSB downward.
    function automatic logic [31:0] gray2bin_f(logic [31:0] g);
        logic [31:0] b;
        b[31] = g[31];
        for (int i = 30; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/gray_wptr_full_if.sv
// Write-port bundle of the async FIFO write-side pointer block.
// The master drives the push request and synchronised read pointer.
interface gray_wptr_full_if
    import gray_wptr_full_pkg::*;
#(
    parameter int unsigned ADDRSIZE = 8
);
    localparam int unsigned PW = ptrw(ADDRSIZE);

    logic                winc;
    logic [PW-1:0]       wq2_rptr;
    logic [ADDRSIZE-1:0] waddr;
    logic [PW-1:0]       wptr;
    logic                wfull;
    logic                wafull;
    logic [PW-1:0]       wlevel;

    modport master (
        output winc, wq2_rptr,
        input  waddr, wptr, wfull, wafull, wlevel
    );

    modport slave (
        input  winc, wq2_rptr,
        output waddr, wptr, wfull, wafull, wlevel
    );

endinterface

// File: rtl/gray_wptr_full_bin2gray.sv
// Parameterised binary to Gray encoder; purely combinational.
module gray_wptr_full_bin2gray #(
    parameter int unsigned Width = 9
) (
    input  logic [Width-1:0] bin,
    output logic [Width-1:0] gray
);

    assign gray = bin ^ (bin >> 1);

endmodule

// File: rtl/gray_wptr_full.sv
// Async FIFO write-side pointer: binary/Gray write counter, full, almost-full and level flags.
// Flags are computed from next-state pointers so they are valid the cycle after each push.
module gray_wptr_full
    import gray_wptr_full_pkg::*;
#(
    parameter int unsigned ADDRSIZE = 8,
    parameter int unsigned AFULL_TH = 2 ** ADDRSIZE - 2
) (
    input logic              wclk,
    input logic              wrst,
    gray_wptr_full_if.slave  bus
);

    localparam int unsigned PW = ptrw(ADDRSIZE);

    logic [PW-1:0] wbin_q, wbin_d;
    logic [PW-1:0] wptr_q, wgray_d;
    logic [PW-1:0] level_q, level_d;
    logic [PW-1:0] rbin;
    logic          wfull_q, wfull_d;
    logic          wafull_q, wafull_d;
    logic          push;

    gray_wptr_full_bin2gray #(
        .Width(PW)
    ) u_bin2gray (
        .bin  (wbin_d),
        .gray (wgray_d)
    );

    always_comb begin
        push     = bus.winc & ~wfull_q;
        wbin_d   = wbin_q + PW'(push);
        rbin     = PW'(gray2bin_f(32'(bus.wq2_rptr)));
        // Full when the pointers differ only in the lap bit; in Gray that flips the top two bits.
        wfull_d  = (wgray_d == {~bus.wq2_rptr[PW-1:PW-2], bus.wq2_rptr[PW-3:0]});
        level_d  = wbin_d - rbin;
        wafull_d = (32'(level_d) >= AFULL_TH);
    end

    always_ff @(posedge wclk) begin
        if (wrst) begin
            wbin_q   <= '0;
            wptr_q   <= '0;
            level_q  <= '0;
            wfull_q  <= 1'b0;
            wafull_q <= 1'b0;
        end else begin
            wbin_q   <= wbin_d;
            wptr_q   <= wgray_d;
            level_q  <= level_d;
            wfull_q  <= wfull_d;
            wafull_q <= wafull_d;
        end
    end

    assign bus.waddr  = wbin_q[ADDRSIZE-1:0];
    assign bus.wptr   = wptr_q;
    assign bus.wfull  = wfull_q;
    assign bus.wafull = wafull_q;
    assign bus.wlevel = level_q;

endmodule

// File: tb/tb_gray_wptr_full.sv
// Bench for gray_wptr_full: occupancy model in plain integers plus directed literal checks.
module tb_gray_wptr_full;

    localparam int unsigned AW    = 4;
    localparam int unsigned PW    = 5;
    localparam int          DEPTH = 16;
    localparam int          AFT   = 14;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    gray_wptr_full_if #(.ADDRSIZE(AW)) bus ();

    gray_wptr_full #(
        .ADDRSIZE (AW),
        .AFULL_TH (AFT)
    ) dut (
        .wclk (clk),
        .wrst (rst),
        .bus  (bus)
    );

    int   n_chk = 0;
    int   n_fail = 0;
    int   rbin_drv = 0;
    bit   chk_en = 1'b0;

    // Model: count of accepted writes and the occupancy it implies.
    int   m_w = 0;
    int   m_lvl = 0;
    bit   m_rst_edge = 1'b1;
    logic [PW-1:0] prev_wptr = '0;

    assign bus.wq2_rptr = PW'((rbin_drv & 31) ^ ((rbin_drv & 31) >> 1));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int next_w();
        return (m_w + ((bus.winc === 1'b1 && m_lvl != DEPTH) ? 1 : 0)) % 32;
    endfunction

    function automatic int next_lvl();
        return (next_w() - (rbin_drv & 31) + 64) % 32;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_w        <= 0;
            m_lvl      <= 0;
            m_rst_edge <= 1'b1;
        end else begin
            m_w        <= next_w();
            m_lvl      <= next_lvl();
            m_rst_edge <= 1'b0;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("waddr",  32'(bus.waddr),  32'(m_w % DEPTH));
            chk("wptr",   32'(bus.wptr),   32'(m_w ^ (m_w >> 1)));
            chk("wlevel", 32'(bus.wlevel), 32'(m_lvl));
            chk("wfull",  32'(bus.wfull),  32'(m_lvl == DEPTH));
            chk("wafull", 32'(bus.wafull), 32'(m_lvl >= AFT));
            if (!m_rst_edge) begin
                chk("wptr_one_bit", 32'($countones(bus.wptr ^ prev_wptr) <= 1), 32'd1);
            end
        end
        prev_wptr <= bus.wptr;
    end

    task automatic step(input bit w);
        bus.winc = w;
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step(1'b0);
        rst = 1'b0;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_wptr"},   32'(bus.wptr),   32'd0);
        chk({tag, "_waddr"},  32'(bus.waddr),  32'd0);
        chk({tag, "_wfull"},  32'(bus.wfull),  32'd0);
        chk({tag, "_wafull"}, 32'(bus.wafull), 32'd0);
        chk({tag, "_wlevel"}, 32'(bus.wlevel), 32'd0);
    endtask

    initial begin
        bus.winc = 1'b1;
        // Reset with winc held high must leave everything at zero.
        rst = 1'b1;
        step(1'b1);
        chk_en = 1'b1;
        step(1'b1);
        chk_zero("rst");
        rst = 1'b0;
        step(1'b1);
        chk("p1_waddr",  32'(bus.waddr),  32'd1);
        chk("p1_wptr",   32'(bus.wptr),   32'b00001);
        chk("p1_wlevel", 32'(bus.wlevel), 32'd1);

        // Fill from empty with the read pointer parked at zero.
        do_reset();
        for (int i = 1; i <= 16; i++) begin
            step(1'b1);
            if (i == 13) begin
                chk("af13_wafull", 32'(bus.wafull), 32'd0);
                chk("af13_wlevel", 32'(bus.wlevel), 32'd13);
            end
            if (i == 14) begin
                chk("af14_wafull", 32'(bus.wafull), 32'd1);
                chk("af14_wlevel", 32'(bus.wlevel), 32'd14);
            end
        end
        chk("full_wfull", 32'(bus.wfull), 32'd1);
        chk("full_wptr",  32'(bus.wptr),  32'b11000);
        chk("full_waddr", 32'(bus.waddr), 32'd0);
        step(1'b1);
        chk("drop_wptr",   32'(bus.wptr),   32'b11000);
        chk("drop_wlevel", 32'(bus.wlevel), 32'd16);
        chk("drop_waddr",  32'(bus.waddr),  32'd0);

        // One read becomes visible: full clears, then one more push refills.
        rbin_drv = 1;
        step(1'b0);
        chk("rd_wfull",  32'(bus.wfull),  32'd0);
        chk("rd_wlevel", 32'(bus.wlevel), 32'd15);
        step(1'b1);
        chk("refill_wfull",  32'(bus.wfull),  32'd1);
        chk("refill_wlevel", 32'(bus.wlevel), 32'd16);
        chk("refill_wptr",   32'(bus.wptr),   32'b11001);

        // Wrap the pointer with the read side trailing closely.
        rbin_drv = 0;
        do_reset();
        for (int i = 0; i < 40; i++) begin
            rbin_drv = (i == 0) ? 0 : (i - 1) % 32;
            step(1'b1);
            chk("wrap_lvl_le2", 32'(bus.wlevel <= 2), 32'd1);
            chk("wrap_nofull",  32'(bus.wfull),       32'd0);
        end
        chk("wrap_wptr",   32'(bus.wptr),   32'b01100);
        chk("wrap_wlevel", 32'(bus.wlevel), 32'd2);

        // Reset while full.
        rbin_drv = 0;
        do_reset();
        for (int i = 0; i < 16; i++) step(1'b1);
        chk("pre_rst_wfull", 32'(bus.wfull), 32'd1);
        rst = 1'b1;
        step(1'b1);
        chk_zero("rst_full");
        rst = 1'b0;
        step(1'b0);
        chk_zero("post_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
